matrix_ctrl_regs: RTL and testbench

//  Wishbone responder for the LED matrix control registers at `MATRIX_START.

---
 rtl/matrix_ctrl_regs_pkg.sv | 27 ++
 rtl/matrix_ctrl_regs_wishbone_slave_ack.sv | 68 ++++++
 rtl/matrix_ctrl_regs.sv | 127 ++++++++++++
 tb/tb_matrix_ctrl_regs.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_ctrl_regs_pkg.sv
// Shared constants for the LED matrix control register block: window base,
// register offsets, CTRL/STATUS bit positions and the bus handshake states.
package matrix_ctrl_regs_pkg;

  localparam logic [15:0] MATRIX_START  = 16'h0100;

  localparam logic [2:0]  MATRIX_ADDR_L  = 3'd0;
  localparam logic [2:0]  MATRIX_ADDR_H  = 3'd1;
  localparam logic [2:0]  MATRIX_CTRL    = 3'd2;
  localparam logic [2:0]  MATRIX_BRIGHT  = 3'd3;
  localparam logic [2:0]  MATRIX_STATUS  = 3'd4;
  localparam logic [2:0]  MATRIX_FCNT    = 3'd5;

  localparam int CTRL_ENABLE_BIT    = 0;
  localparam int CTRL_IRQ_EN_BIT    = 1;
  localparam int STATUS_PENDING_BIT = 0;
  localparam int STATUS_FLIP_BIT    = 1;

  localparam logic [2:0]  CTI_INCR = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } wb_state_e;

endpackage

// File: rtl/matrix_ctrl_regs_wishbone_slave_ack.sv
// Wishbone responder handshake: optional wait states, single-cycle ack and
// zero-wait incrementing bursts. do_access marks the edge a register op lands.
module wishbone_slave_ack
  import matrix_ctrl_regs_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cyc,
  input  logic       stb,
  input  logic       hit,
  input  logic [2:0] cti,
  output logic       ack,
  output logic       do_access
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  wb_state_e  state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       req;

  assign req = cyc & stb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ack      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req && hit) begin
          if (WAIT_STATES == 0) begin
            state_nx = ST_ACK;
          end else begin
            state_nx = ST_WAIT;
            cnt_nx   = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        // An abandoned request leaves without touching any register.
        if (!req)              state_nx = ST_IDLE;
        else if (cnt == 4'd0)  state_nx = ST_ACK;
        else                   cnt_nx   = cnt - 4'd1;
      end
      ST_ACK: begin
        ack = 1'b1;
        if (cti == CTI_INCR && req && hit) state_nx = ST_ACK;
        else                               state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign do_access = ack & req & hit;

endmodule

// File: rtl/matrix_ctrl_regs.sv
// LED matrix control registers with double-buffered framebuffer base commit at
// frame_start_i. Define MATRIX_IRQ_EN to build the page-flip interrupt logic.
module matrix_ctrl_regs
  import matrix_ctrl_regs_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 16,
  parameter int                       DATA_WIDTH    = 8,
  parameter int                       DATA_BYTES    = 1,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS  = ADDRESS_WIDTH'(MATRIX_START),
  parameter int                       WAIT_STATES   = 0,
  parameter logic [15:0]              RESET_FRAME   = 16'h0000
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [ADDRESS_WIDTH-1:0] adr_i,
  input  logic [DATA_WIDTH-1:0]    dat_i,
  output logic [DATA_WIDTH-1:0]    dat_o,
  input  logic                     we_i,
  input  logic [DATA_BYTES-1:0]    sel_i,
  input  logic                     stb_i,
  input  logic                     cyc_i,
  output logic                     ack_o,
  input  logic [2:0]               cti_i,
  input  logic                     frame_start_i,
  output logic [15:0]              frame_addr_o,
  output logic [7:0]               brightness_o,
  output logic                     enable_o,
  output logic                     irq_o
);

  logic        hit, do_access, wr, commit;
  logic [2:0]  off;
  logic [7:0]  wd, rdata;
  logic [15:0] staged;
  logic        pending;
  logic [7:0]  fcnt;
  logic        flip_rd, irq_en_rd;

  assign hit    = (adr_i[ADDRESS_WIDTH-1:3] == BASE_ADDRESS[ADDRESS_WIDTH-1:3]);
  assign off    = adr_i[2:0];
  assign wd     = dat_i[7:0];
  assign wr     = do_access & we_i & sel_i[0];
  assign commit = frame_start_i & pending;

  wishbone_slave_ack #(
    .WAIT_STATES (WAIT_STATES)
  ) u_ack (
    .clk       (clk_i),
    .rst       (rst_i),
    .cyc       (cyc_i),
    .stb       (stb_i),
    .hit       (hit),
    .cti       (cti_i),
    .ack       (ack_o),
    .do_access (do_access)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      staged       <= RESET_FRAME;
      frame_addr_o <= RESET_FRAME;
      pending      <= 1'b0;
      fcnt         <= 8'd0;
      brightness_o <= 8'hFF;
      enable_o     <= 1'b1;
    end else begin
      // Commit samples the pre-write staging value, so a coincident ADDR_H
      // write lands in the next frame.
      if (commit) begin
        frame_addr_o <= staged;
        fcnt         <= fcnt + 8'd1;
      end
      if (wr && off == MATRIX_ADDR_H) pending <= 1'b1;
      else if (commit)                pending <= 1'b0;
      if (wr) begin
        case (off)
          MATRIX_ADDR_L: staged[7:0]  <= wd;
          MATRIX_ADDR_H: staged[15:8] <= wd;
          MATRIX_CTRL:   enable_o     <= wd[CTRL_ENABLE_BIT];
          MATRIX_BRIGHT: brightness_o <= wd;
          default: ;
        endcase
      end
    end
  end

`ifdef MATRIX_IRQ_EN
  logic irq_en, flip_flag;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_en    <= 1'b0;
      flip_flag <= 1'b0;
    end else begin
      if (wr && off == MATRIX_CTRL) irq_en <= wd[CTRL_IRQ_EN_BIT];
      if (commit)
        flip_flag <= 1'b1;
      else if (wr && off == MATRIX_STATUS && wd[STATUS_FLIP_BIT])
        flip_flag <= 1'b0;
    end
  end

  assign irq_o     = flip_flag & irq_en;
  assign flip_rd   = flip_flag;
  assign irq_en_rd = irq_en;
`else
  assign irq_o     = 1'b0;
  assign flip_rd   = 1'b0;
  assign irq_en_rd = 1'b0;
`endif

  always_comb begin
    rdata = 8'h00;
    case (off)
      MATRIX_ADDR_L: rdata = staged[7:0];
      MATRIX_ADDR_H: rdata = staged[15:8];
      MATRIX_CTRL:   rdata = {6'b0, irq_en_rd, enable_o};
      MATRIX_BRIGHT: rdata = brightness_o;
      MATRIX_STATUS: rdata = {6'b0, flip_rd, pending};
      MATRIX_FCNT:   rdata = fcnt;
      default:       rdata = 8'h00;
    endcase
  end

  assign dat_o = ack_o ? DATA_WIDTH'(rdata) : '0;

endmodule

// File: tb/tb_matrix_ctrl_regs.sv
// Directed bench for matrix_ctrl_regs: a zero-wait instance and a 3-wait-state
// instance share the bus, each selected by its own cyc line.
module tb_matrix_ctrl_regs;
  import matrix_ctrl_regs_pkg::*;

  localparam logic [15:0] BASE = 16'h0100;
`ifdef MATRIX_IRQ_EN
  localparam bit IRQ_BUILD = 1'b1;
`else
  localparam bit IRQ_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] adr = 16'h0;
  logic [7:0]  dat_w = 8'h0;
  logic        we = 1'b0;
  logic [0:0]  sel = 1'b1;
  logic        stb = 1'b0;
  logic [2:0]  cti = 3'b000;
  logic        cyc0 = 1'b0, cyc1 = 1'b0;
  logic        fs = 1'b0;

  logic [7:0]  dat0, dat1, br0, br1;
  logic        ack0, ack1, en0, en1, irq0, irq1;
  logic [15:0] fa0, fa1;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_fcnt = 0;

  always #5 clk = ~clk;

  matrix_ctrl_regs dut0 (
    .clk_i(clk), .rst_i(rst), .adr_i(adr), .dat_i(dat_w), .dat_o(dat0),
    .we_i(we), .sel_i(sel), .stb_i(stb), .cyc_i(cyc0), .ack_o(ack0),
    .cti_i(cti), .frame_start_i(fs), .frame_addr_o(fa0),
    .brightness_o(br0), .enable_o(en0), .irq_o(irq0)
  );

  matrix_ctrl_regs #(.WAIT_STATES(3), .RESET_FRAME(16'h1234)) dut1 (
    .clk_i(clk), .rst_i(rst), .adr_i(adr), .dat_i(dat_w), .dat_o(dat1),
    .we_i(we), .sel_i(sel), .stb_i(stb), .cyc_i(cyc1), .ack_o(ack1),
    .cti_i(cti), .frame_start_i(fs), .frame_addr_o(fa1),
    .brightness_o(br1), .enable_o(en1), .irq_o(irq1)
  );

  // Single bus cycle; held until the edge that closes the ack.
  task automatic bus(input bit which, input bit wr, input logic [15:0] a,
                     input logic [7:0] wd, input bit sel0, input bit fs_on_ack,
                     output logic [7:0] rdv, output int lat, output bit got);
    @(negedge clk);
    adr = a; dat_w = wd; we = wr; sel = sel0; stb = 1'b1; cti = 3'b000;
    if (which) cyc1 = 1'b1; else cyc0 = 1'b1;
    got = 1'b0; lat = 0; rdv = 8'h00;
    for (int i = 1; i <= 32 && !got; i++) begin
      @(negedge clk);
      if ((which ? ack1 : ack0) === 1'b1) begin
        got = 1'b1; lat = i; rdv = which ? dat1 : dat0;
      end
    end
    if (got && fs_on_ack) fs = 1'b1;
    @(posedge clk); #1;
    cyc0 = 1'b0; cyc1 = 1'b0; stb = 1'b0; we = 1'b0; sel = 1'b1; fs = 1'b0;
  endtask

  task automatic wr_reg(input bit which, input logic [2:0] off, input logic [7:0] d,
                        input bit fs_on_ack);
    logic [7:0] v; int lat; bit got;
    bus(which, 1'b1, BASE + 16'(off), d, 1'b1, fs_on_ack, v, lat, got);
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL wr_timeout: off %0d got no ack, required ack within 32 cycles", off);
    end
  endtask

  task automatic rd_reg(input bit which, input logic [2:0] off, output logic [7:0] v,
                        output int lat);
    bit got;
    bus(which, 1'b0, BASE + 16'(off), 8'h00, 1'b1, 1'b0, v, lat, got);
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL rd_timeout: off %0d got no ack, required ack within 32 cycles", off);
    end
  endtask

  task automatic pulse_frame();
    @(negedge clk); fs = 1'b1;
    @(negedge clk); fs = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if (fa0 !== 16'h0000) begin n_fail++; $display("FAIL reset_frame0: got %h need %h", fa0, 16'h0000); end
    n_tests++; if (fa1 !== 16'h1234) begin n_fail++; $display("FAIL reset_frame1: got %h need %h", fa1, 16'h1234); end
    n_tests++; if (br0 !== 8'hFF) begin n_fail++; $display("FAIL reset_bright: got %h need ff", br0); end
    n_tests++; if (en0 !== 1'b1) begin n_fail++; $display("FAIL reset_enable: got %b need 1", en0); end
    n_tests++; if (ack0 !== 1'b0 || dat0 !== 8'h00) begin n_fail++; $display("FAIL reset_bus: ack %b dat %h need 0 00", ack0, dat0); end
    n_tests++; if (irq0 !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b need 0", irq0); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    adr = BASE + 16'(MATRIX_BRIGHT); dat_w = 8'h11; we = 1'b1; sel = 1'b1; stb = 1'b1; cyc0 = 1'b1;
    @(negedge clk);
    n_tests++; if (ack0 !== 1'b1) begin n_fail++; $display("FAIL mid_ack_before: got %b need 1", ack0); end
    #1 rst = 1'b1;
    #1;
    n_tests++; if (ack0 !== 1'b0) begin n_fail++; $display("FAIL mid_ack_drop: got %b need 0", ack0); end
    @(negedge clk);
    cyc0 = 1'b0; stb = 1'b0; we = 1'b0; rst = 1'b0;
    @(negedge clk);
    n_tests++; if (br0 !== 8'hFF) begin n_fail++; $display("FAIL mid_write_lost: got %h need ff", br0); end
  endtask

  task automatic test_commit();
    logic [7:0] v; int lat;
    wr_reg(0, MATRIX_ADDR_L, 8'h00, 0);
    wr_reg(0, MATRIX_ADDR_H, 8'h04, 0);
    n_tests++; if (fa0 !== 16'h0000) begin n_fail++; $display("FAIL commit_early: got %h need 0000", fa0); end
    rd_reg(0, MATRIX_STATUS, v, lat);
    n_tests++; if (v !== 8'h01) begin n_fail++; $display("FAIL commit_pending: got %h need 01", v); end
    pulse_frame(); exp_fcnt++;
    n_tests++; if (fa0 !== 16'h0400) begin n_fail++; $display("FAIL commit_addr: got %h need 0400", fa0); end
    rd_reg(0, MATRIX_STATUS, v, lat);
    n_tests++; if (v !== (IRQ_BUILD ? 8'h02 : 8'h00)) begin n_fail++; $display("FAIL commit_status: got %h need %h", v, IRQ_BUILD ? 8'h02 : 8'h00); end
    rd_reg(0, MATRIX_FCNT, v, lat);
    n_tests++; if (v !== 8'd1) begin n_fail++; $display("FAIL commit_fcnt: got %0d need 1", v); end
    pulse_frame();
    rd_reg(0, MATRIX_FCNT, v, lat);
    n_tests++; if (v !== 8'd1 || fa0 !== 16'h0400) begin n_fail++; $display("FAIL idle_frame: fcnt %0d addr %h need 1 0400", v, fa0); end
  endtask

  task automatic test_same_edge();
    logic [7:0] v; int lat;
    wr_reg(0, MATRIX_ADDR_L, 8'h55, 0);
    wr_reg(0, MATRIX_ADDR_H, 8'h06, 1);
    n_tests++; if (fa0 !== 16'h0400) begin n_fail++; $display("FAIL same_edge_hold: got %h need 0400", fa0); end
    rd_reg(0, MATRIX_STATUS, v, lat);
    n_tests++; if (v[0] !== 1'b1) begin n_fail++; $display("FAIL same_edge_pending: got %b need 1", v[0]); end
    pulse_frame(); exp_fcnt++;
    n_tests++; if (fa0 !== 16'h0655) begin n_fail++; $display("FAIL same_edge_next: got %h need 0655", fa0); end
    wr_reg(0, MATRIX_ADDR_H, 8'h07, 0);
    wr_reg(0, MATRIX_ADDR_H, 8'h08, 1); exp_fcnt++;
    n_tests++; if (fa0 !== 16'h0755) begin n_fail++; $display("FAIL same_edge_old: got %h need 0755", fa0); end
    rd_reg(0, MATRIX_STATUS, v, lat);
    n_tests++; if (v[0] !== 1'b1) begin n_fail++; $display("FAIL same_edge_set_wins: got %b need 1", v[0]); end
    pulse_frame(); exp_fcnt++;
    n_tests++; if (fa0 !== 16'h0855) begin n_fail++; $display("FAIL same_edge_new: got %h need 0855", fa0); end
    wr_reg(0, MATRIX_ADDR_H, 8'h09, 0);
    wr_reg(0, MATRIX_ADDR_L, 8'h99, 0);
    pulse_frame(); exp_fcnt++;
    n_tests++; if (fa0 !== 16'h0999) begin n_fail++; $display("FAIL latest_low: got %h need 0999", fa0); end
    rd_reg(0, MATRIX_FCNT, v, lat);
    n_tests++; if (v !== 8'(exp_fcnt)) begin n_fail++; $display("FAIL same_edge_fcnt: got %0d need %0d", v, exp_fcnt); end
  endtask

  task automatic test_wait();
    logic [7:0] v; int lat; int acks;
    rd_reg(0, MATRIX_BRIGHT, v, lat);
    n_tests++; if (lat != 1) begin n_fail++; $display("FAIL latency_ws0: got %0d need 1", lat); end
    rd_reg(1, MATRIX_BRIGHT, v, lat);
    n_tests++; if (lat != 4 || v !== 8'hFF) begin n_fail++; $display("FAIL latency_ws3: lat %0d data %h need 4 ff", lat, v); end
    @(negedge clk);
    adr = BASE + 16'(MATRIX_BRIGHT); dat_w = 8'h3C; we = 1'b1; sel = 1'b1; stb = 1'b1; cyc1 = 1'b1;
    acks = 0;
    repeat (2) begin @(negedge clk); if (ack1) acks++; end
    cyc1 = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (6) begin @(negedge clk); if (ack1) acks++; end
    n_tests++; if (acks != 0) begin n_fail++; $display("FAIL abort_ack: got %0d acks need 0", acks); end
    n_tests++; if (br1 !== 8'hFF) begin n_fail++; $display("FAIL abort_write: got %h need ff", br1); end
  endtask

  task automatic test_burst();
    logic [7:0] v; int lat; bit got;
    @(negedge clk);
    adr = BASE + 16'(MATRIX_ADDR_L); dat_w = 8'h12; we = 1'b1; sel = 1'b1;
    stb = 1'b1; cyc0 = 1'b1; cti = CTI_INCR;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin @(negedge clk); got = ack0; end
    n_tests++; if (!got) begin n_fail++; $display("FAIL burst_beat0: got no ack, need ack"); end
    @(posedge clk); #1;
    adr = BASE + 16'(MATRIX_ADDR_H); dat_w = 8'h34; cti = 3'b111;
    @(negedge clk);
    n_tests++; if (ack0 !== 1'b1) begin n_fail++; $display("FAIL burst_beat1: ack %b need 1", ack0); end
    @(posedge clk); #1;
    cyc0 = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
    @(negedge clk);
    n_tests++; if (ack0 !== 1'b0) begin n_fail++; $display("FAIL burst_end: ack %b need 0", ack0); end
    rd_reg(0, MATRIX_STATUS, v, lat);
    n_tests++; if (v[0] !== 1'b1) begin n_fail++; $display("FAIL burst_pending: got %b need 1", v[0]); end
    pulse_frame(); exp_fcnt++;
    n_tests++; if (fa0 !== 16'h3412) begin n_fail++; $display("FAIL burst_staged: got %h need 3412", fa0); end
  endtask

  task automatic test_sel_ctrl();
    logic [7:0] v; int lat; bit got;
    bus(0, 1'b1, BASE + 16'(MATRIX_BRIGHT), 8'h22, 1'b0, 1'b0, v, lat, got);
    n_tests++; if (!got || br0 !== 8'hFF) begin n_fail++; $display("FAIL sel_noop: ack %b bright %h need 1 ff", got, br0); end
    wr_reg(0, MATRIX_BRIGHT, 8'h80, 0);
    rd_reg(0, MATRIX_BRIGHT, v, lat);
    n_tests++; if (br0 !== 8'h80 || v !== 8'h80) begin n_fail++; $display("FAIL bright_write: port %h read %h need 80", br0, v); end
    wr_reg(0, MATRIX_CTRL, 8'h00, 0);
    n_tests++; if (en0 !== 1'b0) begin n_fail++; $display("FAIL enable_clear: got %b need 0", en0); end
    wr_reg(0, 3'd6, 8'hAA, 0);
    rd_reg(0, 3'd6, v, lat);
    n_tests++; if (v !== 8'h00) begin n_fail++; $display("FAIL unused_off: got %h need 00", v); end
  endtask

  task automatic test_irq();
    logic [7:0] v; int lat;
`ifdef MATRIX_IRQ_EN
    wr_reg(0, MATRIX_STATUS, 8'h02, 0);
    wr_reg(0, MATRIX_CTRL, 8'h03, 0);
    rd_reg(0, MATRIX_CTRL, v, lat);
    n_tests++; if (v !== 8'h03 || irq0 !== 1'b0) begin n_fail++; $display("FAIL irq_ctrl: ctrl %h irq %b need 03 0", v, irq0); end
    wr_reg(0, MATRIX_ADDR_H, 8'h0A, 0);
    pulse_frame(); exp_fcnt++;
    n_tests++; if (irq0 !== 1'b1) begin n_fail++; $display("FAIL irq_set: got %b need 1", irq0); end
    wr_reg(0, MATRIX_STATUS, 8'h02, 0);
    n_tests++; if (irq0 !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b need 0", irq0); end
`else
    wr_reg(0, MATRIX_CTRL, 8'h03, 0);
    rd_reg(0, MATRIX_CTRL, v, lat);
    n_tests++; if (v !== 8'h01) begin n_fail++; $display("FAIL irq_ctrl: got %h need 01", v); end
    wr_reg(0, MATRIX_ADDR_H, 8'h0A, 0);
    pulse_frame(); exp_fcnt++;
    n_tests++; if (irq0 !== 1'b0) begin n_fail++; $display("FAIL irq_tied: got %b need 0", irq0); end
    rd_reg(0, MATRIX_STATUS, v, lat);
    n_tests++; if (v !== 8'h00) begin n_fail++; $display("FAIL irq_status: got %h need 00", v); end
`endif
    n_tests++; if (fa0 !== 16'h0A12 || en0 !== 1'b1) begin n_fail++; $display("FAIL irq_commit: addr %h en %b need 0a12 1", fa0, en0); end
  endtask

  task automatic test_miss();
    logic [7:0] v; int lat; bit got;
    bus(0, 1'b1, BASE + 16'h0008, 8'h00, 1'b1, 1'b0, v, lat, got);
    n_tests++; if (got) begin n_fail++; $display("FAIL miss_above: ack after %0d cycles, need none", lat); end
    bus(0, 1'b1, BASE - 16'h0001, 8'h00, 1'b1, 1'b0, v, lat, got);
    n_tests++; if (got) begin n_fail++; $display("FAIL miss_below: ack after %0d cycles, need none", lat); end
    n_tests++; if (br0 !== 8'h80) begin n_fail++; $display("FAIL miss_write: bright %h need 80", br0); end
  endtask

  task automatic test_fcnt_wrap();
    logic [7:0] v; int lat;
    while (exp_fcnt < 255) begin
      wr_reg(0, MATRIX_ADDR_H, 8'h01, 0);
      pulse_frame(); exp_fcnt++;
    end
    rd_reg(0, MATRIX_FCNT, v, lat);
    n_tests++; if (v !== 8'hFF) begin n_fail++; $display("FAIL fcnt_255: got %0d need 255", v); end
    wr_reg(0, MATRIX_ADDR_H, 8'h02, 0);
    pulse_frame(); exp_fcnt = 0;
    rd_reg(0, MATRIX_FCNT, v, lat);
    n_tests++; if (v !== 8'h00) begin n_fail++; $display("FAIL fcnt_wrap: got %0d need 0", v); end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_commit();
    test_same_edge();
    test_wait();
    test_burst();
    test_sel_ctrl();
    test_irq();
    test_miss();
    test_fcnt_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at 1 ms, need completion");
    $fatal(1);
  end

endmodule
